// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter sharing the register file write port.
// One winner per cycle is registered onto rf_wr_en/rf_wr_addr/rf_dat_in.
// Optional grant locking (LOCKED state) is compiled in when RWARB_LOCK_EN is defined.
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*(PW+1)-1:0]  req_addr,
  input  logic [NREQ*8-1:0]       req_data,
  input  logic [NREQ-1:0]         req_lock,
  output logic [NREQ-1:0]         req_ready,
  output logic                    rf_wr_en,
  output logic [PW:0]             rf_wr_addr,
  output logic [7:0]              rf_dat_in,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic [7:0]              conflict_cnt
);
  localparam int AW  = PW + 1;
  localparam int IDW = $clog2(NREQ);
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  typedef enum logic [0:0] {ST_ARB = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t           r_state, w_state_next;
  logic [IDW-1:0]   r_ptr, w_ptr_next;
  logic [IDW-1:0]   r_grant_id;
  logic             r_wr_en;
  logic [AW-1:0]    r_wr_addr;
  logic [7:0]       r_dat_in;
  logic [7:0]       r_conflict_cnt;

  logic             w_found;
  logic [IDW-1:0]   w_rr_win;
  logic [IDW:0]     w_idx;
  logic             w_grant;
  logic [IDW-1:0]   w_win;
  logic             w_contended;
  logic [AW-1:0]    w_addr_arr [NREQ];
  logic [7:0]       w_data_arr [NREQ];

  // (a + 1) mod NREQ without relying on NREQ being a power of two
  function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] a);
    logic [IDW:0] s;
    s = {1'b0, a} + (IDW+1)'(1);
    if (s >= NREQ_W) s = '0;
    return s[IDW-1:0];
  endfunction

  // Unpack requester fields and form the one-hot ready vector
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_addr_arr[gi] = req_addr[gi*AW +: AW];
      assign w_data_arr[gi] = req_data[gi*8 +: 8];
      assign req_ready[gi]  = w_grant && (w_win == IDW'(gi));
    end
  endgenerate

  assign w_contended = ($countones(req_valid) > 1);

  // Round-robin search: first valid requester starting at r_ptr
  always_comb begin
    w_found  = 1'b0;
    w_rr_win = '0;
    w_idx    = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
      if (w_idx >= NREQ_W) w_idx = w_idx - NREQ_W;
      if (!w_found && req_valid[w_idx[IDW-1:0]]) begin
        w_found  = 1'b1;
        w_rr_win = w_idx[IDW-1:0];
      end
    end
  end

`ifdef RWARB_LOCK_EN
  logic [IDW-1:0] r_owner, w_owner_next;

  // Next state, pointer, owner and grant decision with locking
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_owner_next = r_owner;
    w_grant      = 1'b0;
    w_win        = w_rr_win;
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
          w_grant = 1'b1;
          if (req_lock[w_rr_win]) begin
            // Pointer stays put while the owner holds the port
            w_state_next = ST_LOCKED;
            w_owner_next = w_rr_win;
          end else begin
            w_ptr_next = f_next(w_rr_win);
          end
        end
      end
      ST_LOCKED: begin
        w_win = r_owner;
        if (req_valid[r_owner]) begin
          w_grant = 1'b1;
          if (!req_lock[r_owner]) begin
            w_state_next = ST_ARB;
            w_ptr_next   = f_next(r_owner);
          end
        end else begin
          // Owner went idle: release without a transfer this cycle
          w_state_next = ST_ARB;
          w_ptr_next   = f_next(r_owner);
        end
      end
      default: w_state_next = ST_ARB;
    endcase
  end

  // Lock owner register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_owner <= '0;
    else        r_owner <= w_owner_next;
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^req_lock;

  // Next state, pointer and grant decision (pure round-robin)
  always_comb begin
    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    w_grant      = 1'b0;
    w_win        = w_rr_win;
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
          w_grant    = 1'b1;
          w_ptr_next = f_next(w_rr_win);
        end
      end
      default: w_state_next = ST_ARB;
    endcase
  end
`endif

  // State and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ARB;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
    end
  end

  // Register file write port: capture the winner, hold address/data when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_dat_in   <= '0;
      r_grant_id <= '0;
    end else begin
      r_wr_en <= w_grant;
      if (w_grant) begin
        r_wr_addr  <= w_addr_arr[w_win];
        r_dat_in   <= w_data_arr[w_win];
        r_grant_id <= w_win;
      end
    end
  end

  // Saturating count of cycles with two or more requesters valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_contended && (r_conflict_cnt != 8'hFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 8'd1;
    end
  end

  assign rf_wr_en     = r_wr_en;
  assign rf_wr_addr   = r_wr_addr;
  assign rf_dat_in    = r_dat_in;
  assign grant_id     = r_grant_id;
  assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Testbench for reg_write_arbiter: directed steps plus randomized traffic
// checked against a behavioural model of the arbitration rules.
module tb_reg_write_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 3;
  localparam int AW   = PW + 1;
`ifdef RWARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*8-1:0]  req_data;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ-1:0]    req_ready;
  logic               rf_wr_en;
  logic [AW-1:0]      rf_wr_addr;
  logic [7:0]         rf_dat_in;
  logic [1:0]         grant_id;
  logic [7:0]         conflict_cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int       m_ptr, m_gid, m_cnt, m_owner;
  bit       m_locked, m_wr_en;
  int       m_addr, m_data;

  // Simple register file fed by the write port
  logic [7:0] rf_mem [16];

  reg_write_arbiter #(.NREQ(NREQ), .PW(PW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .rf_wr_en     (rf_wr_en),
    .rf_wr_addr   (rf_wr_addr),
    .rf_dat_in    (rf_dat_in),
    .grant_id     (grant_id),
    .conflict_cnt (conflict_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
    end else if (rf_wr_en) begin
      rf_mem[rf_wr_addr] <= rf_dat_in;
    end
  end

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endfunction

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [7:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*8 +: 8]   = d;
  endtask

  function automatic void model_reset();
    m_ptr = 0; m_gid = 0; m_cnt = 0; m_owner = 0;
    m_locked = 1'b0; m_wr_en = 1'b0; m_addr = 0; m_data = 0;
  endfunction

  // Assert reset asynchronously (away from the clock edge), check, then release
  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_wr_en", rf_wr_en, 0);
    chk("rst_wr_addr", rf_wr_addr, 0);
    chk("rst_dat_in", rf_dat_in, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_conflict_cnt", conflict_cnt, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // One clock cycle: check req_ready mid-cycle, advance model, check registers after the edge
  task automatic cycle();
    int win;
    int i;
    logic [NREQ-1:0] exp_ready;
    @(negedge clk);
    win = -1;
    if (m_locked) begin
      if (req_valid[m_owner]) win = m_owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        i = (m_ptr + k) % NREQ;
        if (win < 0 && req_valid[i]) win = i;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    chk("req_ready", req_ready, exp_ready);

    if ($countones(req_valid) >= 2 && m_cnt < 255) m_cnt++;
    if (win >= 0) begin
      m_wr_en = 1'b1;
      m_addr  = req_addr[win*AW +: AW];
      m_data  = req_data[win*8 +: 8];
      m_gid   = win;
    end else begin
      m_wr_en = 1'b0;
    end
    if (m_locked) begin
      if (win < 0 || !req_lock[m_owner]) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % NREQ;
      end
    end else if (win >= 0) begin
      if (LOCK_EN && req_lock[win]) begin
        m_locked = 1'b1;
        m_owner  = win;
      end else begin
        m_ptr = (win + 1) % NREQ;
      end
    end

    @(posedge clk);
    #1;
    chk("rf_wr_en", rf_wr_en, m_wr_en);
    chk("rf_wr_addr", rf_wr_addr, m_addr);
    chk("rf_dat_in", rf_dat_in, m_data);
    chk("grant_id", grant_id, m_gid);
    chk("conflict_cnt", conflict_cnt, m_cnt);
    $display("cycle t=%0t valid=%b lock=%b ready=%b wr_en=%0d addr=%0d data=%02h gid=%0d cnt=%0d",
             $time, req_valid, req_lock, req_ready, rf_wr_en, rf_wr_addr, rf_dat_in, grant_id, conflict_cnt);
  endtask

  initial begin
    rst_n     = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    req_lock  = '0;
    model_reset();
    #1;
    do_reset();
    cycle();  // idle: no ready, no write

    // Stream from req0, then reset mid-stream while a write is in flight
    req_valid = 4'b0001;
    set_req(0, 4'd9, 8'h11);
    cycle();
    cycle();
    chk("stream_wr_en", rf_wr_en, 1);
    #2;
    do_reset();

    // First transfer after reset
    set_req(0, 4'd3, 8'hA5);
    cycle();
    chk("post_rst_addr", rf_wr_addr, 3);
    chk("post_rst_data", rf_dat_in, 8'hA5);
    chk("post_rst_gid", grant_id, 0);

    // Fairness: all four valid for eight cycles from a fresh pointer
    do_reset();
    req_valid = 4'b1111;
    for (int r = 0; r < NREQ; r++) set_req(r, 4'(r + 4), 8'(8'h40 + r));
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("fair_order", grant_id, k % 4);
    end
    chk("fair_cnt", conflict_cnt, 8);

    // Wrap/skip: ptr moves to 3, then req1 and req2 compete
    req_valid = 4'b0100;
    cycle();
    req_valid = 4'b0110;
    cycle();
    chk("wrap_req1", grant_id, 1);
    cycle();
    chk("wrap_req2", grant_id, 2);

    // Idle/hold after a write of 0x5C to addr 7
    req_valid = 4'b0001;
    set_req(0, 4'd7, 8'h5C);
    cycle();
    req_valid = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("hold_wr_en", rf_wr_en, 0);
      chk("hold_addr", rf_wr_addr, 7);
      chk("hold_data", rf_dat_in, 8'h5C);
    end

    // End-to-end: req3 writes 0x3C to r2, visible two cycles later
    req_valid = 4'b1000;
    set_req(3, 4'd2, 8'h3C);
    cycle();
    chk("e2e_r2_n1", rf_mem[2], 8'h00);
    req_valid = 4'b0000;
    cycle();
    chk("e2e_r2_n2", rf_mem[2], 8'h3C);

    // Randomized traffic against the model
    for (int k = 0; k < 200; k++) begin
      req_valid = 4'($urandom);
      req_lock  = 4'($urandom & $urandom);
      req_addr  = 16'($urandom);
      req_data  = 32'($urandom);
      cycle();
    end
    req_lock = '0;

    // Saturation of the contention counter
    req_valid = 4'b1111;
    for (int k = 0; k < 300; k++) cycle();
    chk("sat_cnt", conflict_cnt, 255);
    req_valid = 4'b0010;
    cycle();
    req_valid = 4'b0000;
    cycle();
    chk("sat_hold", conflict_cnt, 255);

`ifdef RWARB_LOCK_EN
    // Lock: req1 holds the port while req0 stalls
    do_reset();
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0011;
    req_lock  = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("lock_owner", grant_id, 1);
    end
    req_lock = 4'b0000;
    cycle();
    chk("lock_last", grant_id, 1);
    cycle();
    chk("lock_req0", grant_id, 0);
    // Owner valid drop releases the lock with no transfer that cycle
    req_valid = 4'b0100;
    req_lock  = 4'b0100;
    cycle();
    req_valid = 4'b0001;
    req_lock  = 4'b0000;
    cycle();
    chk("drop_no_wr", rf_wr_en, 0);
    cycle();
    chk("drop_req0", grant_id, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
